// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: right-aligned payload sent MSB first, optional even-parity bit (SPTX_PARITY_EN).
// Latency: first bit one cycle after the accepting edge; a frame takes len cycles (len+1 with parity).
// Backpressure: ready is high in IDLE and in the final frame cycle; start is ignored whenever ready is low.
module serial_pattern_tx #(
   parameter int WIDTH = 21,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [LEN_W-1:0] len,
   output logic             out,
   output logic             ready,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);

`ifdef SPTX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
   typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    len_c;
   logic [CW-1:0]    shamt;
   logic             last;
   logic             accept;
`ifdef SPTX_PARITY_EN
   logic             par;
`endif

   // Oversized lengths are clamped; the payload is left-justified so the MSB is always the next bit out.
   always_comb begin
      len_c = '0;
      if (32'(len) > WIDTH)
         len_c = CW'(WIDTH);
      else
         len_c = CW'(len);
      shamt = CW'(WIDTH) - len_c;
   end

`ifdef SPTX_PARITY_EN
   assign last = (state == S_PARITY);
`else
   assign last = (state == S_SHIFT) && (cnt == CW'(1));
`endif

   assign accept = start && ((state == S_IDLE) || last) && (len_c != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept) state_nxt = S_SHIFT;
`ifdef SPTX_PARITY_EN
         S_SHIFT:
            if (cnt == CW'(1)) state_nxt = S_PARITY;
         S_PARITY:
            state_nxt = accept ? S_SHIFT : S_IDLE;
`else
         S_SHIFT:
            if (cnt == CW'(1)) state_nxt = accept ? S_SHIFT : S_IDLE;
`endif
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      out   = 1'b0;
      busy  = 1'b0;
      done  = last;
      ready = (state == S_IDLE) || last;
      case (state)
         S_SHIFT: begin
            out  = sreg[WIDTH-1];
            busy = 1'b1;
         end
`ifdef SPTX_PARITY_EN
         S_PARITY: begin
            out  = par;
            busy = 1'b1;
         end
`endif
         default: begin
            out  = 1'b0;
            busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
`ifdef SPTX_PARITY_EN
         par  <= 1'b0;
`endif
      end else if (accept) begin
         sreg <= data_in << shamt;
         cnt  <= len_c;
`ifdef SPTX_PARITY_EN
         par  <= 1'b0;
`endif
      end else if (state == S_SHIFT) begin
         sreg <= sreg << 1;
         cnt  <= cnt - CW'(1);
`ifdef SPTX_PARITY_EN
         par  <= par ^ sreg[WIDTH-1];
`endif
      end
   end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed and randomized frames checked against a bit-list reference model of the transmitter.
module tb_serial_pattern_tx;
   localparam int W = 21;
`ifdef SPTX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [4:0]   len = '0;
   logic         out, ready, busy, done;

   int n_chk = 0;
   int n_fail = 0;

   serial_pattern_tx #(.WIDTH(W), .LEN_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .len(len),
      .out(out), .ready(ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected serial stream: payload bits MSB first, then the even-parity bit when enabled.
   function automatic logic model_bit(input logic [W-1:0] d, input int l, input int k);
      int   L;
      int   ones;
      L = (l > W) ? W : l;
      if (k < L) return d[L-1-k];
      ones = 0;
      for (int i = 0; i < L; i++) ones += int'(d[i]);
      return logic'(ones % 2);
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, "_out"},   32'(out),   32'd0);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_done"},  32'(done),  32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   task automatic start_req(input logic [W-1:0] d, input int l);
      start   = 1'b1;
      data_in = d;
      len     = 5'(l);
   endtask

   // Runs from the accepting edge; returns in the last checked cycle (before its closing edge) with start low.
   task automatic play(input string tag, input logic [W-1:0] d, input int l, input int upto);
      int L, n, nc;
      L  = (l > W) ? W : l;
      n  = L + PAR;
      nc = (upto > 0 && upto < n) ? upto : n;
      @(posedge clk); #1;
      for (int k = 0; k < nc; k++) begin
         chk({tag, "_out"},   32'(out),   32'(model_bit(d, l, k)));
         chk({tag, "_busy"},  32'(busy),  32'd1);
         chk({tag, "_done"},  32'(done),  32'(k == n - 1));
         chk({tag, "_ready"}, 32'(ready), 32'(k == n - 1));
         if (k == nc - 1) begin
            start = 1'b0;
         end else begin
            start   = 1'($urandom_range(0, 1));
            data_in = W'($urandom);
            len     = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      logic [W-1:0] d;
      int           l;
      #1;
      check_idle("reset");
      start_req(21'h1FFFFF, 21);
      repeat (2) begin
         @(posedge clk); #1;
         check_idle("start_in_reset");
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("after_release");

      start_req(21'b010100111110001011100, 21);
      play("basic", 21'b010100111110001011100, 21, 0);
      @(posedge clk); #1;
      check_idle("basic_end");

      start_req(21'd5, 3);
      play("b2b_a", 21'd5, 3, 0);
      start_req(21'd3, 2);
      play("b2b_b", 21'd3, 2, 0);
      @(posedge clk); #1;
      check_idle("b2b_end");

      start_req(21'h1ABCDE, 0);
      @(posedge clk); #1;
      start = 1'b0;
      check_idle("len0_a");
      @(posedge clk); #1;
      check_idle("len0_b");

      start_req(21'h15A5A5, 31);
      play("len31", 21'h15A5A5, 31, 0);
      @(posedge clk); #1;
      check_idle("len31_end");

      start_req(21'b010100111110001011100, 21);
      play("pre_rst", 21'b010100111110001011100, 21, 10);
      rst_n = 1'b0;
      #1;
      check_idle("rst_mid");
      start_req(21'h0F0F0F, 12);
      @(posedge clk); #1;
      check_idle("rst_hold");
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle("rst_release");
      start_req(21'b010100111110001011100, 21);
      play("post_rst", 21'b010100111110001011100, 21, 0);
      @(posedge clk); #1;
      check_idle("post_rst_end");

      for (int i = 0; i < 40; i++) begin
         d = W'($urandom);
         l = $urandom_range(0, 31);
         start_req(d, l);
         if (l == 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            check_idle("rnd_len0");
         end else begin
            play("rnd", d, l, 0);
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
               check_idle("rnd_gap");
            end
         end
      end
      @(posedge clk); #1;
      check_idle("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 21, SHALL set the maximum frame length in bits and the width of data_in.
REQ-002 Parameter LEN_W, default 5, SHALL set the width of len.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: frame request; it SHALL be sampled only on an edge where ready=1.
REQ-006 Port data_in, input, WIDTH: frame payload, right-aligned; bit len-1 is the first bit transmitted.
REQ-007 Port len, input, LEN_W: frame length in bits, sampled together with data_in.
REQ-008 Port out, output, 1: serial bit stream, one bit per clock, MSB first.
REQ-009 Port ready, output, 1: start will be accepted on this edge.
REQ-010 Port busy, output, 1: a frame is in transmission.
REQ-011 Port done, output, 1: one-cycle pulse coincident with the final bit of a frame.

Function
REQ-012 The block SHALL have states IDLE, SHIFT and, only when SPTX_PARITY_EN is defined, PARITY.
REQ-013 In IDLE, out=0, busy=0, done=0 and ready=1.
REQ-014 A start accepted with 1<=len<=WIDTH SHALL latch data_in and len, enter SHIFT and drive out=data_in[len-1] in the next cycle.
REQ-015 A start with len=0 SHALL be ignored: the state remains IDLE and nothing is transmitted.
REQ-016 A start with len>WIDTH SHALL be clamped to len=WIDTH.
REQ-017 In SHIFT, out SHALL present latched bits len-1 down to 0, each held for exactly one cycle, with no gaps; busy=1.
REQ-018 In SHIFT, ready SHALL be 0 except in the final-bit cycle, where ready=1.
REQ-019 In the final SHIFT cycle (no parity), done=1; a start accepted on that edge SHALL drive the new frame's first bit in the very next cycle, giving zero idle gap between frames.
REQ-020 After the final bit with no start accepted, the state SHALL return to IDLE and out SHALL return to 0.
REQ-021 A start received while ready=0 SHALL be ignored, and the frame in progress SHALL be unaffected.
REQ-022 Changes to data_in or len after acceptance SHALL have no effect on the frame in progress.
REQ-023 Latency from the accepting edge to the first bit SHALL be exactly 1 cycle; a frame SHALL occupy len cycles, or len+1 cycles with parity.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force IDLE, with out=0, busy=0, done=0, ready=1, the shift register cleared and the bit counter set to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL accept only new start requests.
REQ-026 While rst_n=0, start SHALL be ignored.

Configuration
REQ-027 With macro SPTX_PARITY_EN defined, the block SHALL transmit one extra PARITY cycle after bit 0, with out equal to the even-parity bit (XOR of all transmitted data bits).
REQ-028 With SPTX_PARITY_EN defined, done and the ready=1 back-to-back window SHALL move from the final SHIFT cycle to the PARITY cycle.
REQ-029 Without SPTX_PARITY_EN, the PARITY state and its logic SHALL be absent, and frames are exactly len bits.

Verification
REQ-030 Basic frame: after reset, start with data_in=21'b010100111110001011100 and len=21 -> out over the next 21 cycles is 0,1,0,1,0,0,1,1,1,1,1,0,0,0,1,0,1,1,1,0,0; done=1 only in cycle 21; then out=0 and ready=1.
REQ-031 Back-to-back: start with data_in=3'b101 and len=3, then start with data_in=2'b11 and len=2 asserted on the done edge -> out=1,0,1,1,1 contiguous; done pulses in cycles 3 and 5.
REQ-032 Boundaries: a start with len=0 -> busy stays 0 and there is no done pulse; a start with len=31 -> exactly 21 bits are sent; a start during busy -> ignored, and the current frame completes unchanged.
REQ-033 Reset mid-frame: rst_n=0 asserted at bit 10 of the REQ-030 frame -> out=0, busy=0 immediately; no done pulse; a new start after release sends a clean frame.
REQ-034 Parity (SPTX_PARITY_EN defined): the REQ-030 frame -> 22 cycles, with cycle 22 out=1 (eleven ones) and done=1 in cycle 22.
